// File: rtl/expr_pkg.sv
// expr_pkg: shared ASCII constants, LFSR taps and FSM state encoding for expr_emitter
package expr_pkg;
  localparam logic [7:0] CH_0    = 8'h30;
  localparam logic [7:0] CH_PLUS = 8'h2B;
  localparam logic [7:0] CH_STAR = 8'h2A;
  localparam logic [7:0] CH_LPAR = 8'h28;
  localparam logic [7:0] CH_RPAR = 8'h29;
  // Feedback taps at bits 15, 13, 12 and 10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_TERM   = 3'd1,
    S_OP     = 3'd2,
    S_GDIG   = 3'd3,
    S_GOP    = 3'd4,
    S_GCLOSE = 3'd5
  } state_t;
endpackage

// File: rtl/expr_lfsr16.sv
// expr_lfsr16: 16-bit Fibonacci LFSR with seed load (zero seed replaced by DEFAULT_SEED) and advance enable
module expr_lfsr16
  import expr_pkg::*;
#(
  parameter logic [15:0] DEFAULT_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        adv,
  output logic [15:0] state
);
  logic [15:0] lfsr_q, lfsr_d;
  // Load has priority over advance; otherwise hold
  always_comb lfsr_d = load ? ((load_val == 16'd0) ? DEFAULT_SEED : load_val)
                     : adv  ? {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)}
                     : lfsr_q;
  // State register
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) lfsr_q <= DEFAULT_SEED;
    else lfsr_q <= lfsr_d;
  assign state = lfsr_q;
endmodule

// File: rtl/expr_emitter.sv
// expr_emitter: serial pseudo-random ASCII expression generator over valid/ready; EXPR_GROUP_EN enables parenthesized groups
module expr_emitter
  import expr_pkg::*;
#(
  parameter logic [15:0] DEFAULT_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        start,
  input  logic [15:0] seed,
  input  logic [3:0]  term_cnt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_char,
  output logic        out_last,
  output logic        busy,
  output logic        done
);
  state_t      state_q, state_d;
  logic [3:0]  terms_left_q, terms_left_d;
  logic [1:0]  inner_left_q, inner_left_d;
  logic        done_q, done_d;
  logic [15:0] lfsr;
  logic        hs, accept, grp;
  logic [3:0]  dv;
  logic [7:0]  dig, op_ch;
  logic        unused_bits;

  assign hs     = out_valid & out_ready;
  assign accept = start & (state_q == S_IDLE);

  expr_lfsr16 #(.DEFAULT_SEED(DEFAULT_SEED)) u_lfsr (
    .clk      (clk),
    .clr_n    (clr_n),
    .load     (accept),
    .load_val (seed),
    .adv      (hs),
    .state    (lfsr)
  );

`ifdef EXPR_GROUP_EN
  assign grp = lfsr[15];
`else
  assign grp = 1'b0;
`endif

  assign dv          = (lfsr[3:0] >= 4'd10) ? lfsr[3:0] - 4'd10 : lfsr[3:0];
  assign dig         = CH_0 + {4'd0, dv};
  assign op_ch       = lfsr[8] ? CH_STAR : CH_PLUS;
  assign unused_bits = ^{lfsr[15:9], lfsr[7:4]};

  // Moore outputs and next-state: each transition out of a non-idle state waits for a handshake
  always_comb begin
    state_d      = state_q;
    terms_left_d = terms_left_q;
    inner_left_d = inner_left_q;
    out_char     = 8'h00;
    out_last     = 1'b0;
    case (state_q)
      S_IDLE: if (accept) begin
        state_d      = S_TERM;
        terms_left_d = (term_cnt == 4'd0) ? 4'd0 : term_cnt - 4'd1;
      end
      S_TERM: begin
        out_char = grp ? CH_LPAR : dig;
        out_last = !grp && terms_left_q == 4'd0;
        if (hs && grp) begin
          inner_left_d = lfsr[14:13];
          state_d      = S_GDIG;
        end else if (hs) state_d = (terms_left_q == 4'd0) ? S_IDLE : S_OP;
      end
      S_OP: begin
        out_char = op_ch;
        if (hs) begin
          terms_left_d = terms_left_q - 4'd1;
          state_d      = S_TERM;
        end
      end
`ifdef EXPR_GROUP_EN
      S_GDIG: begin
        out_char = dig;
        if (hs) state_d = (inner_left_q == 2'd0) ? S_GCLOSE : S_GOP;
      end
      S_GOP: begin
        out_char = op_ch;
        if (hs) begin
          inner_left_d = inner_left_q - 2'd1;
          state_d      = S_GDIG;
        end
      end
      S_GCLOSE: begin
        out_char = CH_RPAR;
        out_last = terms_left_q == 4'd0;
        if (hs) state_d = (terms_left_q == 4'd0) ? S_IDLE : S_OP;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign done_d    = hs & out_last;
  assign out_valid = state_q != S_IDLE;
  assign busy      = state_q != S_IDLE;
  assign done      = done_q;

  // FSM, counters and done pulse register
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) begin
      state_q      <= S_IDLE;
      terms_left_q <= 4'd0;
      inner_left_q <= 2'd0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      terms_left_q <= terms_left_d;
      inner_left_q <= inner_left_d;
      done_q       <= done_d;
    end
endmodule

// File: tb/tb_expr_emitter.sv
// tb_expr_emitter: table-driven and scoreboard checks of expr_emitter (follows EXPR_GROUP_EN)
module tb_expr_emitter;
  logic        clk = 1'b0, clr_n = 1'b0, start = 1'b0, out_ready = 1'b1;
  logic [15:0] seed = 16'd0;
  logic [3:0]  term_cnt = 4'd0;
  logic        out_valid, out_last, busy, done;
  logic [7:0]  out_char;
  int          total = 0, bad = 0;
  logic [7:0]  exp_q[$];
  bit          rand_bp = 1'b0;

  typedef struct {
    logic [15:0] s;
    logic [3:0]  n;
    string       e;
  } vec_t;
  vec_t vecs[$];

  expr_emitter dut (
    .clk(clk), .clr_n(clr_n), .start(start), .seed(seed), .term_cnt(term_cnt),
    .out_valid(out_valid), .out_ready(out_ready), .out_char(out_char),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  function automatic logic [15:0] nxt(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic logic [7:0] dch(input logic [3:0] v);
    int d;
    d = (v >= 10) ? int'(v) - 10 : int'(v);
    return 8'(48 + d);
  endfunction

  // Reference generator: walks the grammar directly, pushing expected characters
  task automatic gen_model(input logic [15:0] s, input logic [3:0] n);
    logic [15:0] lf;
    int nt, k;
    lf = (s == 16'd0) ? 16'hACE1 : s;
    nt = (n == 4'd0) ? 1 : int'(n);
    for (int t = 0; t < nt; t++) begin
`ifdef EXPR_GROUP_EN
      if (lf[15]) begin
        exp_q.push_back(8'h28);
        k  = int'(lf[14:13]);
        lf = nxt(lf);
        for (int i = 0; i <= k; i++) begin
          exp_q.push_back(dch(lf[3:0]));
          lf = nxt(lf);
          if (i < k) begin
            exp_q.push_back(lf[8] ? 8'h2A : 8'h2B);
            lf = nxt(lf);
          end
        end
        exp_q.push_back(8'h29);
        lf = nxt(lf);
      end else
`endif
      begin
        exp_q.push_back(dch(lf[3:0]));
        lf = nxt(lf);
      end
      if (t < nt - 1) begin
        exp_q.push_back(lf[8] ? 8'h2A : 8'h2B);
        lf = nxt(lf);
      end
    end
  endtask

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  task automatic kick(input logic [15:0] s, input logic [3:0] n);
    @(posedge clk); #2;
    start = 1'b1; seed = s; term_cnt = n;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_done();
    bit got;
    got = 1'b0;
    for (int k = 0; k < 1000 && !got; k++) begin
      @(negedge clk);
      got = done;
    end
    chk("done_seen", got, 1);
    chk("busy_at_done", busy, 0);
    chk("valid_at_done", out_valid, 0);
    chk("queue_drained", exp_q.size(), 0);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
  endtask

  // Scoreboard: every handshake pops one expected character
  always @(negedge clk)
    if (clr_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_char got=%0h want=none", out_char);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        chk("char", out_char, e);
        chk("last", out_last, exp_q.size() == 0);
      end
    end

  // Random backpressure on out_ready when enabled
  always @(posedge clk)
    if (rand_bp) begin
      #2;
      out_ready = 1'($urandom_range(0, 1));
    end

  initial begin
    bit got;
    logic [15:0] rs;
    logic [3:0]  rn;
    vecs.push_back('{16'h0003, 4'd1, "3"});
    vecs.push_back('{16'h0012, 4'd2, "2+8"});
    vecs.push_back('{16'h000A, 4'd1, "0"});
    vecs.push_back('{16'h000C, 4'd1, "2"});
    vecs.push_back('{16'h0009, 4'd1, "9"});
    vecs.push_back('{16'h0080, 4'd2, "0*0"});
`ifdef EXPR_GROUP_EN
    vecs.push_back('{16'h8005, 4'd1, "(1)"});
`else
    vecs.push_back('{16'h8003, 4'd1, "3"});
`endif

    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_char", out_char, 0);
    chk("rst_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(posedge clk); #2;
    clr_n = 1'b1;

    foreach (vecs[i]) begin
      push_str(vecs[i].e);
      kick(vecs[i].s, vecs[i].n);
      wait_done();
    end

    // start while busy is ignored
    push_str("2+8");
    @(posedge clk); #2;
    start = 1'b1; seed = 16'h0012; term_cnt = 4'd2;
    @(posedge clk); #2;
    seed = 16'h0003; term_cnt = 4'd1;
    @(posedge clk); #2;
    start = 1'b0;
    wait_done();

    // backpressure: first character held, lfsr frozen
    push_str("2+8");
    out_ready = 1'b0;
    kick(16'h0012, 4'd2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_char", out_char, 8'h32);
      chk("bp_last", out_last, 0);
      chk("bp_busy", busy, 1);
    end
    @(posedge clk); #2;
    out_ready = 1'b1;
    wait_done();

    // asynchronous reset during OP
    push_str("2+8");
    kick(16'h0012, 4'd2);
    @(posedge clk); #2;
    clr_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_char", out_char, 0);
    exp_q.delete();
    got = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      got = got | done;
    end
    chk("mid_rst_no_done", got, 0);
    @(posedge clk); #2;
    clr_n = 1'b1;

    // zero seed and zero term count
`ifdef EXPR_GROUP_EN
    push_str("(3*5)");
`else
    push_str("1");
`endif
    kick(16'h0000, 4'd0);
    wait_done();

    // random expressions with random backpressure against the model
    for (int i = 0; i < 6; i++) begin
      rs = 16'($urandom);
      rn = 4'($urandom_range(0, 15));
      gen_model(rs, rn);
      rand_bp = 1'b1;
      kick(rs, rn);
      wait_done();
      rand_bp = 1'b0;
      @(posedge clk); #3;
      out_ready = 1'b1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
